// File: rtl/thor2025_preg_alloc_ctrl.sv
// Physical-register free-list controller for the rename stage: bitmap allocator with up to three
// all-or-nothing grants per cycle, up to three frees from commit, and one-cycle checkpoint restore.
module thor2025_preg_alloc_ctrl #(
  parameter int unsigned Preg = 48,
  parameter int unsigned Areg = 32,
  parameter int unsigned Nchk = 4,
  localparam int unsigned TagW = $clog2(Preg),
  localparam int unsigned ChkW = $clog2(Nchk),
  localparam int unsigned CntW = $clog2(Preg + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      alloc_req,
  output logic            alloc_ok,
  output logic [2:0]      alloc_v,
  output logic [TagW-1:0] alloc_tag0,
  output logic [TagW-1:0] alloc_tag1,
  output logic [TagW-1:0] alloc_tag2,
  input  logic [2:0]      free_v,
  input  logic [TagW-1:0] free0,
  input  logic [TagW-1:0] free1,
  input  logic [TagW-1:0] free2,
  input  logic            chk_save,
  input  logic [ChkW-1:0] chk_save_id,
  input  logic            chk_restore,
  input  logic [ChkW-1:0] chk_restore_id,
  output logic [CntW-1:0] free_count,
  output logic            free_err
);

  localparam logic [Preg-1:0] ResetAvail = {Preg{1'b1}} << Areg;

  logic [Preg-1:0] avail_q, avail_d;
  logic [Preg-1:0] chk_q [Nchk];
  logic [CntW-1:0] free_count_q;
  logic [2:0]      alloc_v_q, alloc_v_d;
  logic [TagW-1:0] tag_q [3];
  logic [TagW-1:0] tag_d [3];
  logic            free_err_q;

  logic [TagW-1:0] cand [3];
  logic [TagW-1:0] free_tag [3];
  logic [Preg-1:0] mask1, mask2;
  logic [Preg-1:0] granted, freed;
  logic [1:0]      k, sel2;
  logic            err_d;

  function automatic logic [TagW-1:0] lowest(input logic [Preg-1:0] v);
    logic [TagW-1:0] idx;
    idx = '0;
    for (int i = Preg - 1; i >= 0; i--) begin
      if (v[i]) idx = TagW'(i);
    end
    return idx;
  endfunction

  function automatic logic [CntW-1:0] popcount(input logic [Preg-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < Preg; i++) cnt += int'(v[i]);
    return CntW'(cnt);
  endfunction

  // Find-first-one chain: each stage masks off the previous winner.
  always_comb begin
    cand[0] = lowest(avail_q);
    mask1   = avail_q & ~(Preg'(1) << cand[0]);
    cand[1] = lowest(mask1);
    mask2   = mask1 & ~(Preg'(1) << cand[1]);
    cand[2] = lowest(mask2);
  end

  assign k        = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]} + {1'b0, alloc_req[2]};
  assign alloc_ok = (free_count_q >= CntW'(k)) && !chk_restore;
  assign sel2     = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};

  always_comb begin
    granted   = '0;
    alloc_v_d = '0;
    for (int s = 0; s < 3; s++) tag_d[s] = tag_q[s];
    if (alloc_ok) begin
      alloc_v_d = alloc_req;
      // Candidates are packed onto requested slots in ascending slot order.
      if (alloc_req[0]) tag_d[0] = cand[0];
      if (alloc_req[1]) tag_d[1] = cand[{1'b0, alloc_req[0]}];
      if (alloc_req[2]) tag_d[2] = cand[sel2];
      for (int s = 0; s < 3; s++) begin
        if (alloc_req[s]) granted[tag_d[s]] = 1'b1;
      end
    end
  end

  always_comb begin
    free_tag[0] = free0;
    free_tag[1] = free1;
    free_tag[2] = free2;
    freed       = '0;
    err_d       = 1'b0;
    // Checked against the registered bitmap, so same-cycle duplicates merge without error.
    for (int n = 0; n < 3; n++) begin
      if (free_v[n]) begin
        if (int'(free_tag[n]) >= Preg) begin
          err_d = 1'b1;
        end else if (avail_q[free_tag[n]]) begin
          err_d = 1'b1;
        end else begin
          freed[free_tag[n]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (chk_restore) avail_d = chk_q[chk_restore_id] | freed;
    else             avail_d = (avail_q & ~granted) | freed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avail_q      <= ResetAvail;
      free_count_q <= CntW'(Preg - Areg);
      alloc_v_q    <= '0;
      free_err_q   <= 1'b0;
      for (int i = 0; i < Nchk; i++) chk_q[i] <= ResetAvail;
      for (int s = 0; s < 3; s++) tag_q[s] <= '0;
    end else begin
      avail_q      <= avail_d;
      free_count_q <= popcount(avail_d);
      alloc_v_q    <= alloc_v_d;
      free_err_q   <= free_err_q | err_d;
      for (int s = 0; s < 3; s++) tag_q[s] <= tag_d[s];
      // Retired registers stay free in every checkpoint; a restore drops the save.
      for (int i = 0; i < Nchk; i++) begin
        if (chk_save && !chk_restore && (ChkW'(i) == chk_save_id)) chk_q[i] <= avail_d;
        else                                                       chk_q[i] <= chk_q[i] | freed;
      end
    end
  end

  assign alloc_v    = alloc_v_q;
  assign alloc_tag0 = tag_q[0];
  assign alloc_tag1 = tag_q[1];
  assign alloc_tag2 = tag_q[2];
  assign free_count = free_count_q;
  assign free_err   = free_err_q;

endmodule

// File: tb/tb_thor2025_preg_alloc_ctrl.sv
// Scoreboard bench for the preg free-list controller: the driver queues hand-computed expectations,
// a monitor pops one per cycle and compares alloc_ok and the registered outputs.
module tb_thor2025_preg_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] alloc_req = '0;
  logic       alloc_ok;
  logic [2:0] alloc_v;
  logic [5:0] alloc_tag0, alloc_tag1, alloc_tag2;
  logic [2:0] free_v = '0;
  logic [5:0] free0 = '0, free1 = '0, free2 = '0;
  logic       chk_save = 1'b0;
  logic [1:0] chk_save_id = '0;
  logic       chk_restore = 1'b0;
  logic [1:0] chk_restore_id = '0;
  logic [5:0] free_count;
  logic       free_err;

  thor2025_preg_alloc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_ok       (alloc_ok),
    .alloc_v        (alloc_v),
    .alloc_tag0     (alloc_tag0),
    .alloc_tag1     (alloc_tag1),
    .alloc_tag2     (alloc_tag2),
    .free_v         (free_v),
    .free0          (free0),
    .free1          (free1),
    .free2          (free2),
    .chk_save       (chk_save),
    .chk_save_id    (chk_save_id),
    .chk_restore    (chk_restore),
    .chk_restore_id (chk_restore_id),
    .free_count     (free_count),
    .free_err       (free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   id;
    logic ok;
    logic [2:0] av;
    logic [5:0] t0, t1, t2, fc;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic drive(input logic r, input logic [2:0] req, input logic [2:0] fv,
                       input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2,
                       input logic sv, input logic [1:0] sid, input logic rs,
                       input logic [1:0] rid);
    @(negedge clk);
    rst = r; alloc_req = req; free_v = fv; free0 = f0; free1 = f1; free2 = f2;
    chk_save = sv; chk_save_id = sid; chk_restore = rs; chk_restore_id = rid;
  endtask

  task automatic expect_v(input logic ok, input logic [2:0] av, input logic [5:0] t0,
                          input logic [5:0] t1, input logic [5:0] t2, input logic [5:0] fc,
                          input logic err);
    exp_t e;
    vec_id++;
    e.id = vec_id; e.ok = ok; e.av = av; e.t0 = t0; e.t1 = t1; e.t2 = t2; e.fc = fc; e.err = err;
    sb.push_back(e);
  endtask

  task automatic cmp(input int id, input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0d expected %0d", id, name, act, exp);
    end
  endtask

  // Monitor: alloc_ok is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic ok_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      ok_s = alloc_ok;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cmp(e.id, "alloc_ok", int'(ok_s), int'(e.ok));
        cmp(e.id, "alloc_v", int'(alloc_v), int'(e.av));
        cmp(e.id, "tag0", int'(alloc_tag0), int'(e.t0));
        cmp(e.id, "tag1", int'(alloc_tag1), int'(e.t1));
        cmp(e.id, "tag2", int'(alloc_tag2), int'(e.t2));
        cmp(e.id, "free_count", int'(free_count), int'(e.fc));
        cmp(e.id, "free_err", int'(free_err), int'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // Reset state and basic triple grant
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 0, 0, 0, 16, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 32, 33, 34, 13, 0);
    drive(0, 3'b101, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b101, 35, 33, 36, 11, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 37, 38, 39, 8, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 40, 41, 42, 5, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 43, 44, 45, 2, 0);
    // Partial boundary: two free, three requested
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(0, 3'b000, 43, 44, 45, 2, 0);
    drive(0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b001, 46, 44, 45, 1, 0);
    drive(0, 3'b011, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(0, 3'b000, 46, 44, 45, 1, 0);
    // Free of 40 is not grantable in the same cycle
    drive(0, 3'b011, 3'b001, 40, 0, 0, 0, 0, 0, 0); expect_v(0, 3'b000, 46, 44, 45, 2, 0);
    drive(0, 3'b011, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b011, 40, 47, 45, 0, 0);
    drive(0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(0, 3'b000, 40, 47, 45, 0, 0);
    // Double free of 33 is sticky and leaves the count alone
    drive(0, 3'b000, 3'b001, 33, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 40, 47, 45, 1, 0);
    drive(0, 3'b000, 3'b001, 33, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 40, 47, 45, 1, 1);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 40, 47, 45, 1, 1);
    // Reset with live inputs overrides them
    drive(1, 3'b111, 3'b001, 5, 0, 0, 1, 1, 0, 0); expect_v(0, 3'b000, 0, 0, 0, 16, 0);
    drive(0, 3'b101, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b101, 32, 0, 33, 14, 0);
    // Duplicate tag within a cycle counts once without error
    drive(0, 3'b000, 3'b011, 5, 5, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 32, 0, 33, 15, 0);
    // Checkpoint save, allocate, retire an extra preg, restore
    drive(0, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0, 0); expect_v(1, 3'b000, 32, 0, 33, 15, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 5, 34, 35, 12, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 36, 37, 38, 9, 0);
    drive(0, 3'b000, 3'b001, 6, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 36, 37, 38, 10, 0);
    drive(0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1, 1); expect_v(0, 3'b000, 36, 37, 38, 16, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 5, 6, 34, 13, 0);
    // Save and restore together: restore wins, slot 2 keeps its older contents
    drive(0, 3'b000, 3'b000, 0, 0, 0, 1, 2, 1, 1); expect_v(0, 3'b000, 5, 6, 34, 16, 0);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 2); expect_v(0, 3'b000, 5, 6, 34, 18, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 5, 6, 32, 15, 0);
    // Out-of-range free
    drive(0, 3'b000, 3'b001, 50, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 5, 6, 32, 15, 1);
    drive(0, 3'b000, 3'b001, 33, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 5, 6, 32, 15, 1);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 5, 6, 32, 15, 1);
    drive(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b000, 0, 0, 0, 16, 0);
    drive(0, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0); expect_v(1, 3'b111, 32, 33, 34, 13, 0);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/thor2025_preg_alloc_ctrl.md
# thor2025_preg_alloc_ctrl

Physical-register free-list controller for the Thor2025 rename stage. It keeps a PREG-bit availability bitmap and grants up to three physical registers per cycle to decode. Grants are all-or-nothing. It accepts up to three frees per cycle from commit. It holds NCHK bitmap checkpoints so a branch mispredict can restore the free list in one cycle. It sits between decode/rename (allocation side) and the commit/ROB (free and restore side).

## Interface
- PREG, 48: physical registers; tag width 6.
- AREG, 32: architectural registers; pregs 0..AREG-1 are mapped at reset and therefore busy.
- NCHK, 4: checkpoint slots; checkpoint id width 2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  3  per-slot allocation request from decode (bit n = slot n).
- alloc_ok  out  1  combinational; 1 when all requested slots are granted this cycle.
- alloc_v  out  3  registered; slots granted last cycle.
- alloc_tag0/1/2  out  6 each  registered preg tags for slots 0..2.
- free_v  in  3  per-slot free valid from commit.
- free0/1/2  in  6 each  preg tags to free.
- chk_save  in  1  save checkpoint.
- chk_save_id  in  2  checkpoint slot to save into.
- chk_restore  in  1  restore free list from a checkpoint.
- chk_restore_id  in  2  checkpoint slot to restore from.
- free_count  out  6  registered popcount of the bitmap.
- free_err  out  1  sticky flag; set when a free targets an already-free or out-of-range preg.

## Operation
- Bitmap avail[PREG-1:0]: 1 = free.
- Candidates c0, c1, c2 are the three lowest-numbered set bits of avail (find-first-one chain with masking).
- Granting: let k = popcount(alloc_req).
  - alloc_ok = (free_count >= k) && !chk_restore.
  - k = 0 gives alloc_ok = 1 and no allocation.
- When alloc_ok, candidates are packed onto the requested slots in ascending slot order. Example: req=3'b110 gives tag1=c0, tag2=c1.
- Unrequested slots keep their previous tag value. Their alloc_v bit is 0.
- When !alloc_ok, nothing is allocated and alloc_v is 0. Decode holds alloc_req and retries the next cycle.
- Frees: for each valid free_n, bit free_n is set in avail.
  - If the bit is already 1, or free_n >= PREG, the free is ignored and free_err is set.
  - Duplicate tags within one cycle are a single free and do not set free_err.
- Next-state bitmap: avail_n = (avail & ~granted) | freed.
- Freed bits are not grantable until the following cycle; there is no same-cycle bypass.
- Checkpoints: chk[i] are PREG-bit copies of the bitmap.
  - Every cycle, freed bits are ORed into every chk[i]. A register retired after a checkpoint therefore stays free after restore.
  - On chk_save: chk[chk_save_id] <= avail_n, which includes this cycle's grants and frees.
  - On chk_restore: avail <= chk[chk_restore_id] | freed, and no grant occurs.
- Simultaneous save and restore: restore wins and the save is dropped.
- Simultaneous restore and frees: the frees still apply.
- free_count is recomputed from avail_n each cycle, as a registered popcount.

## Timing
- Reset values:
  - avail: bits AREG..PREG-1 set, all others clear.
  - Every chk[i] equals the reset avail.
  - free_count = 16.
  - alloc_v = 0; alloc_tag0/1/2 = 0.
  - free_err = 0.
- Reset overrides all inputs in the same cycle.
- Allocation latency: request in cycle N with alloc_ok=1 gives alloc_v and tags valid in N+1. Those tags are excluded from the candidates in N+1.
- Free latency: free in cycle N makes the preg grantable in N+1 and counted in free_count in N+1.
- Restore latency: restore in cycle N gives the restored bitmap and free_count in N+1. alloc_ok is 0 in N.
- Full boundary: free_count=0 gives alloc_ok=0 for any nonzero request.
- Partial boundary: free_count=2 with k=3 grants nothing (no partial grant).
- Empty-use boundary: free_count can reach PREG only if AREG registers are freed; the counter width covers 48.

## Test plan
- Reset, then alloc_req=3'b111 → alloc_ok=1; next cycle alloc_v=3'b111, tags 32/33/34, free_count=13.
- Reset, then alloc_req=3'b101 → next cycle tag0=32, tag2=33, alloc_v=3'b101.
- Allocate 15 registers, then alloc_req=3'b011 with one free left → alloc_ok=0, alloc_v=0. Next cycle free0=40 valid; retry → grants the remaining free preg and 40.
- chk_save id 1 at free_count 16. Allocate 6. Free preg 5 (an AREG preg). chk_restore id 1 → free_count=17 and preg 5 is free.
- Free preg 33 while it is already free → free_err=1 and stays set. free_count unchanged.
- chk_save and chk_restore same cycle → chk[save_id] unchanged and the bitmap is restored. Then rst mid-sequence → all reset values return next cycle.
